// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - shared widths, state codes and display select codes
package alu_cmd_sequencer_pkg;

    localparam int X_LEN = 32;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [1:0] SEL_PROMPT = 2'b00;
    localparam logic [1:0] SEL_A      = 2'b01;
    localparam logic [1:0] SEL_B      = 2'b10;
    localparam logic [1:0] SEL_F      = 2'b11;

    function automatic logic [1:0] sel_for(input state_t s);
        case (s)
            S_A:     return SEL_A;
            S_B:     return SEL_B;
            S_SHOW:  return SEL_F;
            default: return SEL_PROMPT;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stability counter and rising-edge press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any sample agreeing with the accepted level restarts the stability window
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - step-button entry sequencer: A, B, opcode, execute, show
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_clr,
    input  logic [X_LEN-1:0] sw,
    output logic [X_LEN-1:0] op_a,
    output logic [X_LEN-1:0] op_b,
    output logic [3:0]       alu_op,
    output logic             ld_f,
    output logic [1:0]       out_sel,
    output logic [2:0]       state
);

    logic step_press;
    logic clr_press;
    logic unused_step_level;
    logic unused_clr_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .level   (unused_step_level),
        .press   (step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clr),
        .level   (unused_clr_level),
        .press   (clr_press)
    );

    state_t           state_q;
    state_t           state_d;
    logic [X_LEN-1:0] op_a_d;
    logic [X_LEN-1:0] op_b_d;
    logic [3:0]       alu_op_d;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a;
        op_b_d   = op_b;
        alu_op_d = alu_op;
        if (clr_press) begin
            state_d  = S_A;
            op_a_d   = '0;
            op_b_d   = '0;
            alu_op_d = '0;
        end else begin
            case (state_q)
                S_A:    if (step_press) begin op_a_d = sw;        state_d = S_B;    end
                S_B:    if (step_press) begin op_b_d = sw;        state_d = S_OP;   end
                S_OP:   if (step_press) begin alu_op_d = sw[3:0]; state_d = S_EXEC; end
                S_EXEC: state_d = S_SHOW;
                S_SHOW: if (step_press) state_d = S_A;
                default: begin
                    state_d  = S_A;
                    op_a_d   = '0;
                    op_b_d   = '0;
                    alu_op_d = '0;
                end
            endcase
        end
    end

    // ld_f and out_sel are decoded from the next state so they stay registered yet aligned with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            op_a    <= '0;
            op_b    <= '0;
            alu_op  <= '0;
            ld_f    <= 1'b0;
            out_sel <= SEL_A;
        end else begin
            state_q <= state_d;
            op_a    <= op_a_d;
            op_b    <= op_b_d;
            alu_op  <= alu_op_d;
            ld_f    <= (state_d == S_EXEC);
            out_sel <= sel_for(state_d);
        end
    end

    assign state = state_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Front-end controller that drives the ALU datapath from the board's raw push-buttons and 32 slide switches.
- A single debounced "step" button walks the operator through four entries: operand A, operand B, opcode, then result display.
- Emits registered operands, the opcode, a one-cycle result-latch strobe and the display select code.
- Replaces the three hand-clocked latch buttons with one clean, single-clock, glitch-free entry protocol.

Parameters:
X_LEN, 32, operand/switch width
DEBOUNCE_CYCLES, 20000, consecutive stable samples (1 ms at 20 MHz) before a button level is accepted
CNT_W, 15, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock (20 MHz)
rst  in  1  synchronous, active-high reset
btn_step  in  1  raw step push-button, asynchronous, bouncy
btn_clr  in  1  raw clear push-button, asynchronous, bouncy
sw  in  X_LEN  slide switches
op_a  out  X_LEN  registered operand A
op_b  out  X_LEN  registered operand B
alu_op  out  4  registered opcode
ld_f  out  1  one-cycle strobe: latch ALU result and flags
out_sel  out  2  display select: 00 = prompt pattern, 01 = A, 10 = B, 11 = F
state  out  3  current state code, for LEDs and debug

Behaviour:
- Reset is synchronous, active-high, single clock domain. On reset: op_a=0, op_b=0, alu_op=0, ld_f=0, out_sel=01, state=S_A, synchronizers and debounce counters cleared, debounced levels=0.
- Each button path:
  - 2-FF synchronizer feeds a counter.
  - The counter increments while the synchronized level differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse.
- Latency: press pulse is high exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the raw button high, provided the button stays high throughout.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse. A held button produces exactly one pulse. Release produces no pulse.
- State codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
- Transitions (step = step press pulse):
  - S_A: out_sel=01. On step: op_a<=sw, go to S_B.
  - S_B: out_sel=10. On step: op_b<=sw, go to S_OP.
  - S_OP: out_sel=00. On step: alu_op<=sw[3:0], go to S_EXEC.
  - S_EXEC: ld_f=1 for this single cycle, go to S_SHOW unconditionally. A step pulse arriving in this cycle is ignored.
  - S_SHOW: out_sel=11. On step: go to S_A. op_a, op_b and alu_op are retained, so A's display shows the previous value until re-entered.
- Clear press, in any state: go to S_A, op_a=op_b=alu_op=0, ld_f=0 next cycle.
- Simultaneous step and clear pulses: clear wins.
- ld_f is never high outside S_EXEC and never high for two consecutive cycles.
- Operand capture uses the sw value sampled on the same edge the state advances. sw is not synchronized, since switches are quasi-static.
- Codes 5-7 on the state register are unreachable. If they occur, force S_A next cycle with outputs as for reset.
- All outputs are registered; no combinational path from any input to any output.
- Reset asserted mid-sequence (e.g. in S_EXEC) overrides all: no ld_f pulse, reset values next edge.

Decomposition:
- Shared package/header: X_LEN, the state codes S_A..S_SHOW, and the out_sel codes SEL_PROMPT/SEL_A/SEL_B/SEL_F (shared with the display mux in the top level).
- One sub-module, btn_debounce: parameters DEBOUNCE_CYCLES and CNT_W; ports clk, rst, btn_raw, level, press. Instantiated twice, once for step and once for clear.

Test Plan (bench sets DEBOUNCE_CYCLES=4, CNT_W=3):
1. Reset, then step press while sw=32'h0000_0005 -> op_a=5, state=1, out_sel=10, pulse 7 edges after press.
2. Full walk with A=5, B=32'hFFFF_FFFB, op sw[3:0]=4'h2 -> op_b=FFFF_FFFB, alu_op=2, ld_f high exactly one cycle in state 3, then state=4, out_sel=11. A further step returns to state 0 with op_a still 5.
3. Bouncy step: raw toggles 1-0-1-0 with 2-cycle highs, then steady high for 10 cycles -> exactly one pulse, single state advance. Holding the button for 100 cycles -> no further advance.
4. In S_OP, pulse btn_clr and btn_step so both debounced pulses land in the same cycle -> state=0, op_a=op_b=alu_op=0, alu_op not loaded.
5. Assert rst during S_EXEC -> ld_f=0 on that edge and after, all outputs at reset values, out_sel=01.
6. Force the state register to 6 via the bench -> state=0 next edge, ld_f stays 0.
